// File: rtl/issue_window.sv
// Issue window: per-slot operand/predicate collection for one E-tile block.
// A slot whose last operand lands at edge N issues on fire after edge N+1; alu_stall holds READY slots.
module issue_window #(
  parameter int NUM_SLOTS = 8,
  parameter int DATA_W    = 64,
  localparam int SW       = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              block_start,
  input  logic              disp_valid,
  input  logic [SW-1:0]     disp_slot,
  input  logic [7:0]        disp_opcode,
  input  logic [2:0]        disp_class,
  input  logic [19:0]       disp_imm,
  input  logic [1:0]        disp_bit,
  input  logic [1:0]        disp_nops,
  input  logic [1:0]        disp_pred,
  input  logic              opnd_valid,
  input  logic [SW-1:0]     opnd_slot,
  input  logic [1:0]        opnd_idx,
  input  logic [DATA_W-1:0] opnd_data,
  input  logic              alu_stall,
  output logic              fire,
  output logic [SW-1:0]     issue_slot,
  output logic [7:0]        issue_opcode,
  output logic [2:0]        issue_class,
  output logic [19:0]       issue_imm,
  output logic [1:0]        issue_bit,
  output logic [DATA_W-1:0] issue_left,
  output logic [DATA_W-1:0] issue_right,
  output logic              block_done,
  output logic              proto_err
);
  typedef enum logic [1:0] {EMPTY, WAIT, READY, DONE} slot_st_t;

  slot_st_t          st      [NUM_SLOTS];
  slot_st_t          st_nx   [NUM_SLOTS];
  logic [7:0]        s_op    [NUM_SLOTS];
  logic [2:0]        s_cls   [NUM_SLOTS];
  logic [19:0]       s_imm   [NUM_SLOTS];
  logic [1:0]        s_bit   [NUM_SLOTS];
  logic [1:0]        s_nops  [NUM_SLOTS];
  logic [1:0]        s_pred  [NUM_SLOTS];
  logic [DATA_W-1:0] s_left  [NUM_SLOTS];
  logic [DATA_W-1:0] s_right [NUM_SLOTS];
  logic [2:0]        have    [NUM_SLOTS];
  logic [2:0]        have_nx [NUM_SLOTS];
  logic              pval    [NUM_SLOTS];
  logic              pval_nx [NUM_SLOTS];
  logic [1:0]        nops_e  [NUM_SLOTS];
  logic [1:0]        pred_e  [NUM_SLOTS];
  logic              load    [NUM_SLOTS];
  logic              take    [NUM_SLOTS];
  logic              sel_vld;
  logic [SW-1:0]     sel;
  logic              err;
  logic              any_load;
  logic              busy_nx;
  logic              any_disp;

  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (st[i] == READY) begin
        sel_vld = 1'b1;
        sel     = SW'(i);
      end
    end
    if (alu_stall) sel_vld = 1'b0;
  end

  // Dispatch is applied before operand capture so a same-cycle operand lands in the fresh slot.
  always_comb begin
    err      = 1'b0;
    any_load = 1'b0;
    busy_nx  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      load[i]    = disp_valid && disp_slot == SW'(i) && st[i] == EMPTY;
      if (disp_valid && disp_slot == SW'(i) && st[i] != EMPTY) err = 1'b1;
      any_load   = any_load | load[i];
      st_nx[i]   = load[i] ? WAIT : st[i];
      have_nx[i] = load[i] ? 3'b000 : have[i];
      nops_e[i]  = load[i] ? disp_nops : s_nops[i];
      pred_e[i]  = load[i] ? disp_pred : s_pred[i];
      take[i]    = opnd_valid && opnd_slot == SW'(i) && opnd_idx != 2'd3;
      if (take[i] && (st_nx[i] == EMPTY || st_nx[i] == DONE || have_nx[i][opnd_idx])) begin
        take[i] = 1'b0;
        err     = 1'b1;
      end
      if (take[i]) have_nx[i][opnd_idx] = 1'b1;
      pval_nx[i] = (take[i] && opnd_idx == 2'd2) ? opnd_data[0] : pval[i];
      if (sel_vld && sel == SW'(i)) begin
        st_nx[i] = DONE;
      end else if (st_nx[i] == WAIT) begin
        if (pred_e[i][1] && have_nx[i][2] && pval_nx[i] != pred_e[i][0])
          st_nx[i] = DONE;
        else if ((have_nx[i][0] || nops_e[i] == 2'd0) && (have_nx[i][1] || !nops_e[i][1]) &&
                 (have_nx[i][2] || !pred_e[i][1]))
          st_nx[i] = READY;
      end
      if (st_nx[i] == WAIT || st_nx[i] == READY) busy_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st[i]      <= EMPTY;
        s_op[i]    <= '0;
        s_cls[i]   <= '0;
        s_imm[i]   <= '0;
        s_bit[i]   <= '0;
        s_nops[i]  <= '0;
        s_pred[i]  <= '0;
        s_left[i]  <= '0;
        s_right[i] <= '0;
        have[i]    <= '0;
        pval[i]    <= 1'b0;
      end
      fire         <= 1'b0;
      issue_slot   <= '0;
      issue_opcode <= '0;
      issue_class  <= '0;
      issue_imm    <= '0;
      issue_bit    <= '0;
      issue_left   <= '0;
      issue_right  <= '0;
      block_done   <= 1'b0;
      proto_err    <= 1'b0;
      any_disp     <= 1'b0;
    end else if (block_start) begin
      for (int i = 0; i < NUM_SLOTS; i++) st[i] <= EMPTY;
      fire       <= 1'b0;
      block_done <= 1'b0;
      proto_err  <= 1'b0;
      any_disp   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st[i]   <= st_nx[i];
        have[i] <= have_nx[i];
        pval[i] <= pval_nx[i];
        if (load[i]) begin
          s_op[i]   <= disp_opcode;
          s_cls[i]  <= disp_class;
          s_imm[i]  <= disp_imm;
          s_bit[i]  <= disp_bit;
          s_nops[i] <= disp_nops;
          s_pred[i] <= disp_pred;
        end
        if (take[i] && opnd_idx == 2'd0) s_left[i]  <= opnd_data;
        if (take[i] && opnd_idx == 2'd1) s_right[i] <= opnd_data;
      end
      fire <= sel_vld;
      if (sel_vld) begin
        issue_slot   <= sel;
        issue_opcode <= s_op[sel];
        issue_class  <= s_cls[sel];
        issue_imm    <= s_imm[sel];
        issue_bit    <= s_bit[sel];
        issue_left   <= (s_nops[sel] != 2'd0) ? s_left[sel] : '0;
        issue_right  <= s_nops[sel][1] ? s_right[sel] : '0;
      end
      proto_err  <= err;
      any_disp   <= any_disp | any_load;
      block_done <= (any_disp | any_load) & ~busy_nx;
    end
  end
endmodule

// File: tb/tb_issue_window.sv
// Randomized and directed bench for issue_window against a slot-level reference model.
module tb_issue_window;
  localparam int N = 8;
  localparam int EMPTY = 0, WAIT = 1, READY = 2, DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        block_start, disp_valid, opnd_valid, alu_stall;
  logic [2:0]  disp_slot, opnd_slot;
  logic [7:0]  disp_opcode;
  logic [2:0]  disp_class;
  logic [19:0] disp_imm;
  logic [1:0]  disp_bit, disp_nops, disp_pred, opnd_idx;
  logic [63:0] opnd_data;
  logic        fire, block_done, proto_err;
  logic [2:0]  issue_slot, issue_class;
  logic [7:0]  issue_opcode;
  logic [19:0] issue_imm;
  logic [1:0]  issue_bit;
  logic [63:0] issue_left, issue_right;

  issue_window #(.NUM_SLOTS(N), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .block_start(block_start),
    .disp_valid(disp_valid), .disp_slot(disp_slot), .disp_opcode(disp_opcode),
    .disp_class(disp_class), .disp_imm(disp_imm), .disp_bit(disp_bit),
    .disp_nops(disp_nops), .disp_pred(disp_pred),
    .opnd_valid(opnd_valid), .opnd_slot(opnd_slot), .opnd_idx(opnd_idx), .opnd_data(opnd_data),
    .alu_stall(alu_stall), .fire(fire), .issue_slot(issue_slot), .issue_opcode(issue_opcode),
    .issue_class(issue_class), .issue_imm(issue_imm), .issue_bit(issue_bit),
    .issue_left(issue_left), .issue_right(issue_right),
    .block_done(block_done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one record per slot, updated once per clock from the current inputs.
  int          m_st [N];
  logic [7:0]  m_op [N];
  logic [2:0]  m_cl [N];
  logic [19:0] m_im [N];
  logic [1:0]  m_bt [N], m_np [N], m_pr [N];
  logic [63:0] m_lv [N], m_rv [N];
  bit          m_hl [N], m_hr [N], m_hp [N], m_pv [N];
  bit          m_any;
  logic        e_fire, e_done, e_err;
  logic [2:0]  e_slot, e_cls;
  logic [7:0]  e_op;
  logic [19:0] e_imm;
  logic [1:0]  e_bit;
  logic [63:0] e_left, e_right;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_st[i] = EMPTY;
    m_any = 0;
    e_fire = 0; e_done = 0; e_err = 0;
    e_slot = 0; e_cls = 0; e_op = 0; e_imm = 0; e_bit = 0; e_left = 0; e_right = 0;
  endtask

  task automatic model_step();
    int  sel = -1;
    bit  err = 0;
    bit  dup;
    bit  busy = 0;
    int  s;
    if (block_start) begin
      for (int i = 0; i < N; i++) m_st[i] = EMPTY;
      e_fire = 0; e_done = 0; e_err = 0; m_any = 0;
      return;
    end
    if (!alu_stall)
      for (int i = N - 1; i >= 0; i--) if (m_st[i] == READY) sel = i;
    e_fire = (sel >= 0);
    if (sel >= 0) begin
      e_slot  = 3'(sel);
      e_op    = m_op[sel];
      e_cls   = m_cl[sel];
      e_imm   = m_im[sel];
      e_bit   = m_bt[sel];
      e_left  = (m_np[sel] != 0) ? m_lv[sel] : 64'd0;
      e_right = (m_np[sel] >= 2) ? m_rv[sel] : 64'd0;
    end
    if (disp_valid) begin
      s = int'(disp_slot);
      if (m_st[s] == EMPTY) begin
        m_st[s] = WAIT; m_op[s] = disp_opcode; m_cl[s] = disp_class; m_im[s] = disp_imm;
        m_bt[s] = disp_bit; m_np[s] = disp_nops; m_pr[s] = disp_pred;
        m_hl[s] = 0; m_hr[s] = 0; m_hp[s] = 0;
        m_any = 1;
      end else err = 1;
    end
    if (opnd_valid && opnd_idx != 2'd3) begin
      s = int'(opnd_slot);
      dup = (opnd_idx == 0) ? m_hl[s] : (opnd_idx == 1) ? m_hr[s] : m_hp[s];
      if (m_st[s] == EMPTY || m_st[s] == DONE || dup) err = 1;
      else if (opnd_idx == 0) begin m_hl[s] = 1; m_lv[s] = opnd_data; end
      else if (opnd_idx == 1) begin m_hr[s] = 1; m_rv[s] = opnd_data; end
      else begin m_hp[s] = 1; m_pv[s] = opnd_data[0]; end
    end
    if (sel >= 0) m_st[sel] = DONE;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == WAIT) begin
        // 1x predicated; low bit is the polarity that lets it fire
        if (m_pr[i][1] && m_hp[i] && m_pv[i] != m_pr[i][0]) m_st[i] = DONE;
        else if ((m_np[i] == 0 || m_hl[i]) && (m_np[i] < 2 || m_hr[i]) && (!m_pr[i][1] || m_hp[i]))
          m_st[i] = READY;
      end
      if (m_st[i] == WAIT || m_st[i] == READY) busy = 1;
    end
    e_err  = err;
    e_done = m_any && !busy;
  endtask

  task automatic compare_all();
    chk("fire", fire, e_fire);
    chk("proto_err", proto_err, e_err);
    chk("block_done", block_done, e_done);
    chk("issue_slot", issue_slot, e_slot);
    chk("issue_opcode", issue_opcode, e_op);
    chk("issue_class", issue_class, e_cls);
    chk("issue_imm", issue_imm, e_imm);
    chk("issue_bit", issue_bit, e_bit);
    chk("issue_left", issue_left, e_left);
    chk("issue_right", issue_right, e_right);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    block_start = 0; disp_valid = 0; opnd_valid = 0; alu_stall = 0;
    disp_slot = 0; disp_opcode = 0; disp_class = 0; disp_imm = 0; disp_bit = 0;
    disp_nops = 0; disp_pred = 0; opnd_slot = 0; opnd_idx = 0; opnd_data = 0;
  endtask

  task automatic disp(input int s, input logic [7:0] op, input logic [1:0] nops, input logic [1:0] pred);
    disp_valid = 1; disp_slot = 3'(s); disp_opcode = op; disp_nops = nops; disp_pred = pred;
    disp_class = 3'(s); disp_imm = 20'hA5000 | 20'(s); disp_bit = 2'(s);
  endtask

  task automatic opnd(input int s, input logic [1:0] idx, input logic [63:0] d);
    opnd_valid = 1; opnd_slot = 3'(s); opnd_idx = idx; opnd_data = d;
  endtask

  // Reset is asserted mid-cycle so the asynchronous clear is observed before any edge.
  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    #2;
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;

    // Two-operand ADD on slot 3
    idle(); block_start = 1; step();
    idle(); disp(3, 8'h01, 2, 0); step();
    idle(); opnd(3, 0, 64'd5); step();
    idle(); step();
    idle(); opnd(3, 1, 64'd7); step();
    chk("t31_early", fire, 0);
    idle(); step();
    chk("t31_fire", fire, 1);
    chk("t31_slot", issue_slot, 3);
    chk("t31_left", issue_left, 5);
    chk("t31_right", issue_right, 7);
    chk("t31_done", block_done, 1);
    idle(); step();
    chk("t31_pulse", fire, 0);

    // Priority of lower slot, then stall holding both READY slots
    idle(); block_start = 1; step();
    idle(); alu_stall = 1; disp(1, 8'h11, 0, 0); step();
    idle(); alu_stall = 1; disp(6, 8'h16, 0, 0); step();
    for (int k = 0; k < 3; k++) begin
      idle(); alu_stall = 1; step();
      chk("t32_stall", fire, 0);
    end
    idle(); step();
    chk("t32_first", fire, 1);
    chk("t32_slot1", issue_slot, 1);
    idle(); step();
    chk("t32_second", fire, 1);
    chk("t32_slot6", issue_slot, 6);
    idle(); step();
    chk("t32_end", fire, 0);

    // Predicate fire-on-true: squash with 0, issue with 1
    idle(); block_start = 1; step();
    idle(); disp(2, 8'h22, 0, 2'b11); step();
    idle(); opnd(2, 2, 64'd0); step();
    chk("t33_squash_done", block_done, 1);
    idle(); step();
    chk("t33_squash_fire", fire, 0);
    idle(); block_start = 1; step();
    idle(); disp(2, 8'h23, 0, 2'b11); step();
    idle(); opnd(2, 2, 64'd1); step();
    idle(); step();
    chk("t33_true_fire", fire, 1);
    chk("t33_true_slot", issue_slot, 2);

    // Protocol errors: duplicate left, operand to empty slot
    idle(); block_start = 1; step();
    idle(); disp(4, 8'h44, 1, 0); step();
    idle(); opnd(4, 0, 64'hAA); step();
    idle(); opnd(4, 0, 64'hBB); step();
    chk("t34_dup_err", proto_err, 1);
    chk("t34_left", issue_left, 64'hAA);
    idle(); opnd(5, 0, 64'hCC); step();
    chk("t34_empty_err", proto_err, 1);
    chk("t34_left_hold", issue_left, 64'hAA);
    idle(); step();
    chk("t34_err_pulse", proto_err, 0);

    // block_start wins over a completing operand; reset drops WAIT slots
    idle(); block_start = 1; step();
    idle(); disp(0, 8'h50, 1, 0); step();
    idle(); block_start = 1; opnd(0, 0, 64'h99); step();
    chk("t35_bs_fire", fire, 0);
    chk("t35_bs_done", block_done, 0);
    idle(); step();
    chk("t35_bs_nofire", fire, 0);
    idle(); disp(1, 8'h51, 2, 0); opnd(1, 0, 64'h12); step();
    idle(); do_reset();
    chk("t35_rst_left", issue_left, 0);
    for (int k = 0; k < 3; k++) begin
      idle(); opnd(1, 1, 64'h34); step();
      chk("t35_rst_fire", fire, 0);
      chk("t35_rst_done", block_done, 0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      idle();
      block_start = ($urandom_range(0, 39) == 0);
      alu_stall   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 4) begin
        disp($urandom_range(0, N - 1), 8'($urandom), 2'($urandom_range(0, 2)), 2'($urandom));
        disp_class = 3'($urandom); disp_imm = 20'($urandom); disp_bit = 2'($urandom);
      end
      if ($urandom_range(0, 9) < 6)
        opnd($urandom_range(0, N - 1), 2'($urandom), {$urandom, $urandom});
      if (c % 500 == 250) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
